// File: rtl/param_mod_counter.sv
// Parametrised modulo counter: up/down, synchronous load/clear, registered tc pulse
// and a saturating wrap-event counter. Define PARAM_MOD_COUNTER_SAT_EN to saturate at the bounds.
module param_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up,
  input  logic [WIDTH-1:0]  mod_max,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WRAP_W-1:0] WRAP_SAT = {WRAP_W{1'b1}};

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (load_val > mod_max) ? mod_max : load_val;
    end else if (en) begin
      if (up) begin
        // >= also pulls a count stranded above a lowered mod_max back into range
        if (q >= mod_max) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
          q_nxt = mod_max;
`else
          q_nxt = '0;
`endif
          tc_nxt = 1'b1;
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
          q_nxt = '0;
`else
          q_nxt = mod_max;
`endif
          tc_nxt = 1'b1;
        end else if (q > mod_max) begin
          q_nxt = mod_max;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      tc       <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
      if (clr)
        wrap_cnt <= '0;
      else if (tc_nxt && (wrap_cnt != WRAP_SAT))
        wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter (WIDTH=4, WRAP_W=2); expectations follow
// the wrap or saturate build selected by PARAM_MOD_COUNTER_SAT_EN.
module tb_param_mod_counter;

  localparam int WIDTH  = 4;
  localparam int WRAP_W = 2;

  logic              clk;
  logic              reset;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              en;
  logic              up;
  logic [WIDTH-1:0]  mod_max;
  logic [WIDTH-1:0]  q;
  logic              tc;
  logic [WRAP_W-1:0] wrap_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] e_q;
  logic             e_tc;

  param_mod_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .mod_max(mod_max), .q(q), .tc(tc), .wrap_cnt(wrap_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    en = 1'b0; up = 1'b1; mod_max = 4'd9;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_q", q, 0);
    check("reset_tc", tc, 0);
    check("reset_wrap", wrap_cnt, 0);

    // up wrap, mod_max=9, 12 edges
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
      e_q = (i <= 9) ? 4'(i) : 4'd9;
      e_tc = (i >= 10);
`else
      e_q = 4'(i % 10);
      e_tc = (i == 10);
`endif
      exp_q.push_back(e_q);
      tick();
      check("up_q", q, exp_q.pop_front());
      check("up_tc", tc, e_tc);
    end
`ifdef PARAM_MOD_COUNTER_SAT_EN
    check("up_wrap", wrap_cnt, 3);
`else
    check("up_wrap", wrap_cnt, 1);
`endif

    // down wrap from q=1
    do_load(4'd1);
    check("load1_q", q, 1);
    check("load1_tc", tc, 0);
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
      e_q = 4'd0;
      e_tc = (i >= 1);
`else
      e_q = (i == 0) ? 4'd0 : ((i == 1) ? 4'd9 : 4'd8);
      e_tc = (i == 1);
`endif
      exp_q.push_back(e_q);
      tick();
      check("down_q", q, exp_q.pop_front());
      check("down_tc", tc, e_tc);
    end
`ifdef PARAM_MOD_COUNTER_SAT_EN
    check("down_wrap", wrap_cnt, 3);
`else
    check("down_wrap", wrap_cnt, 2);
`endif

    // asynchronous reset between edges with q=5
    do_load(4'd5);
    check("load5_q", q, 5);
    #3 reset = 1'b1;
    #1;
    check("async_q", q, 0);
    check("async_tc", tc, 0);
    check("async_wrap", wrap_cnt, 0);
    #2 reset = 1'b0;
    tick();
    check("post_reset_q", q, 0);

    // one wrap at mod_max=0 so clr has something to clear
    mod_max = 4'd0; en = 1'b1; up = 1'b1;
    tick();
    check("m0_tc", tc, 1);
    check("m0_wrap", wrap_cnt, 1);

    // clr beats load and en
    clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; mod_max = 4'd9;
    tick();
    clr = 1'b0; load = 1'b0;
    check("prio_q", q, 0);
    check("prio_tc", tc, 0);
    check("prio_wrap", wrap_cnt, 0);

    // load clamps to mod_max
    do_load(4'd14);
    check("clamp_load_q", q, 9);
    check("clamp_load_tc", tc, 0);
    mod_max = 4'd5; up = 1'b1; en = 1'b1;
    tick();
`ifdef PARAM_MOD_COUNTER_SAT_EN
    check("lowered_up_q", q, 5);
`else
    check("lowered_up_q", q, 0);
`endif
    check("lowered_up_tc", tc, 1);
    check("lowered_up_wrap", wrap_cnt, 1);

    // down clamp from above a lowered mod_max: no event
    mod_max = 4'd9;
    do_load(4'd9);
    mod_max = 4'd5; up = 1'b0; en = 1'b1;
    tick();
    check("down_clamp_q", q, 5);
    check("down_clamp_tc", tc, 0);
    check("down_clamp_wrap", wrap_cnt, 1);
    en = 1'b0;
    tick();
    check("idle_q", q, 5);
    check("idle_tc", tc, 0);

    // wrap_cnt saturation at mod_max=0, alternating direction
    do_clr();
    mod_max = 4'd0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up = i[0];
      tick();
      check("sat_q", q, 0);
      check("sat_tc", tc, 1);
      check("sat_wrap", wrap_cnt, (i < 3) ? i + 1 : 3);
    end

    // mod_max=3 from q=2 going up for 4 edges
    do_clr();
    mod_max = 4'd3;
    do_load(4'd2);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
      e_q = 4'd3;
      e_tc = (i >= 1);
`else
      e_q = (i == 0) ? 4'd3 : 4'(i - 1);
      e_tc = (i == 1);
`endif
      exp_q.push_back(e_q);
      tick();
      check("m3_q", q, exp_q.pop_front());
      check("m3_tc", tc, e_tc);
    end
`ifdef PARAM_MOD_COUNTER_SAT_EN
    check("m3_wrap", wrap_cnt, 3);
`else
    check("m3_wrap", wrap_cnt, 1);
`endif

    // full binary range
    mod_max = 4'd15;
    do_load(4'd15);
    en = 1'b1; up = 1'b1;
    tick();
`ifdef PARAM_MOD_COUNTER_SAT_EN
    check("bin_q", q, 15);
`else
    check("bin_q", q, 0);
`endif
    check("bin_tc", tc, 1);
    en = 1'b0;
    tick();
    check("bin_idle_tc", tc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_mod_counter.md
Name: param_mod_counter

Overview:
- Parametrised successor to the 2-bit enable counter with terminal-count output.
- Adds these over its predecessor:
  - configurable width
  - runtime-programmable modulus
  - up/down direction
  - synchronous load and clear
  - a saturating wrap-event counter
- Used as a general-purpose prescaler or event counter in lab datapaths. Its `tc` pulse can chain to the `en` input of another instance.

Parameters:
- WIDTH, 4, bit width of count value `q`, `load_val` and `mod_max`.
- WRAP_W, 8, bit width of wrap-event counter `wrap_cnt`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of `q`, `tc` and `wrap_cnt`.
- load  input  1  synchronous load of `load_val` into `q`.
- load_val  input  WIDTH  value for load.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- mod_max  input  WIDTH  terminal value; count range is 0..mod_max inclusive.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- wrap_cnt  output  WRAP_W  number of tc events since reset or clr, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk): q=0, tc=0, wrap_cnt=0. Deassertion is sampled at the next rising edge.
- All other updates happen on the rising edge of clk.
- Priority per edge: clr > load > en. With en=0 and no clr or load, q and wrap_cnt hold and tc=0.
- clr: q<=0, tc<=0, wrap_cnt<=0.
- load: q <= min(load_val, mod_max); tc<=0; wrap_cnt holds.
- en=1, up=1:
  - If q >= mod_max (the >= also covers q left above a lowered mod_max): q<=0, tc<=1.
  - Otherwise q<=q+1, tc<=0.
- en=1, up=0:
  - If q == 0: q<=mod_max, tc<=1.
  - If q > mod_max: q<=mod_max, tc<=0 (clamp, no event).
  - Otherwise q<=q-1, tc<=0.
- tc is a single-cycle pulse, high only in the cycle after a wrap edge. Consecutive wraps give tc high on consecutive cycles.
- tc does NOT hold across idle cycles. This is a deliberate change from the predecessor.
- wrap_cnt increments on every edge where tc is set to 1 (same edge, not one cycle later). It saturates at 2^WRAP_W-1 and never rolls over.
- mod_max=0: every enabled edge keeps q=0 and pulses tc, in either direction.
- mod_max=2^WIDTH-1: plain binary wrap. All arithmetic is unsigned, WIDTH bits, with no carry out.
- mod_max may change at any time. It takes effect at the next edge; no state beyond q is affected.
- up may change every cycle; the direction used is the one sampled at the edge.
- Reset mid-count: all outputs go to 0 immediately. Counting resumes from 0 on the first edge with reset low.
- Latency: q, tc and wrap_cnt change one edge after the sampled inputs. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PARAM_MOD_COUNTER_SAT_EN.
- When defined, the counter saturates instead of wrapping:
  - up at q >= mod_max: q<=mod_max, tc<=1.
  - down at q == 0: q<=0, tc<=1.
  - tc stays high on every enabled edge spent at the boundary, and wrap_cnt increments on each of those edges (saturating).
  - The down-direction clamp for q > mod_max is unchanged.
- When undefined: wrap behaviour as specified above.
- The port list is identical in both builds.

Test Plan:
- Reset: assert reset between edges with q=5 -> q=0, tc=0, wrap_cnt=0 immediately, before the next edge.
- Up wrap: WIDTH=4, mod_max=9, en=1, up=1 from 0 for 12 edges -> q runs 1..9,0,1,2. tc high only in the cycle q=0. wrap_cnt=1.
- Down wrap: mod_max=9, q=1, up=0, en=1 for 3 edges -> q=0,9,8. tc high only with q=9. wrap_cnt +1.
- Priority and clamp:
  - clr=1, load=1, en=1 same edge -> q=0, wrap_cnt=0.
  - load=1, load_val=14, mod_max=9 -> q=9, tc=0.
  - Then mod_max=5, up=1, en=1 -> q=0, tc=1.
- Saturation: WRAP_W=2, mod_max=0, en=1 for 5 edges -> tc high every cycle, wrap_cnt sticks at 3.
- SAT_EN build: mod_max=3, up=1, en=1 from q=2 for 4 edges -> q=3,3,3,3. tc high on the last 3 edges. wrap_cnt=3.
